pia_kbd: RTL
============

// Module: pia_kbd
// PURPOSE
//  Apple-1 PIA keyboard port: receive direction of the PIA. Accepts ASCII keys from an
//  external keyboard source over a 4-phase kbd_rdy/kbd_ack handshake and buffers them
//  in a small type-ahead FIFO. The 6502 reads them through KBD and KBDCR (addresses
//  `PIA_KBD_REG / `PIA_KBDCR_REG in PIA_ADDR.vh). Sits beside pia_dsp on the CPU bus.
// PARAMETERS
//  DEPTH   4   type-ahead FIFO entries; power of two, 2..16
//  UPCASE  1   1: map ASCII 'a'..'z' (7'h61..7'h7A) to 'A'..'Z' on accept; 0: pass through
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  reset        in   1   synchronous, ACTIVE-LOW reset (sampled on clk rising edge)
//  Address_Bus  in   16  CPU address
//  WE           in   1   CPU write enable; a cycle with WE=0 at a matched address is a read
//  Data_Out     out  8   read data, combinational from Address_Bus and registered state
//  kbd_rdy      in   1   keyboard: kbd_data valid, key offered
//  kbd_ack      out  1   key accepted (registered)
//  kbd_data     in   7   keyboard ASCII, stable while kbd_rdy=1
// BEHAVIOUR
//  Reset (reset=0 at edge): FIFO empty (count=0, pointers 0), state sIdle, kbd_ack=0.
//   Data_Out then follows the read map with an empty FIFO.
//  Handshake FSM, one-hot: sIdle=2'b01, sAck=2'b10; other encodings -> sIdle.
//   sIdle: if kbd_rdy && !full: push key, kbd_ack<=1, -> sAck. If full: stay, ack=0.
//   sAck : hold kbd_ack=1 until kbd_rdy=0; then kbd_ack<=0, -> sIdle.
//   Exactly one push per rdy/ack cycle, however long kbd_rdy stays high.
//   Accept latency: kbd_ack rises on the first edge where kbd_rdy=1 and FIFO not full.
//  Push data: kbd_data, upcased when UPCASE=1. FIFO stores 7 bits per entry.
//  Read map (combinational):
//   `PIA_KBD_REG   -> {~empty, head[6:0]}; head = 7'h00 when empty
//   `PIA_KBDCR_REG -> {~empty, 7'b0}
//   any other      -> 8'h00
//  Pop: an edge with Address_Bus==`PIA_KBD_REG && !WE pops the head if not empty.
//   Pop on empty is ignored. Reads of KBDCR never pop.
//   The CPU holds an address for one clk per access, so one read is one pop.
//  Writes (WE=1) to KBD/KBDCR are ignored. The CPU cannot inject keys.
//  Simultaneous push and pop:
//   not full: both happen, count unchanged.
//   full: the pop happens and the push is blocked this cycle (full is sampled pre-edge).
//   The key is accepted on the next edge if kbd_rdy is still 1.
//   empty: the pop is ignored and the push happens; the new head is visible next cycle.
//  Pointers wrap modulo DEPTH. count has width clog2(DEPTH)+1; full = (count==DEPTH).
//  Reset mid-handshake: kbd_ack drops at that edge and the FIFO is flushed.
//   If kbd_rdy is still 1 after reset, the same key is accepted again as a new key.
// TESTING
//  1 Reset: reset=0 for 2 clk -> kbd_ack=0; read KBDCR=8'h00, KBD=8'h00.
//  2 Single key: kbd_data=7'h41, rdy high until ack, then low -> ack high 1 clk after rdy.
//    Ack falls 1 clk after rdy falls. KBDCR=8'h80, KBD=8'hC1; after the KBD read, KBDCR=8'h00.
//  3 Upcase: UPCASE=1, key 7'h61 -> KBD=8'hC1. UPCASE=0, key 7'h61 -> KBD=8'hE1.
//  4 Full/back-pressure, DEPTH=4: push 'A'..'D', offer 'E' -> no ack while full.
//    Read KBD once -> returns 8'hC1, 'E' acked, FIFO order B,C,D,E.
//  5 Simultaneous: 2 keys queued, push 'X' on the same edge as a KBD read -> count stays 2.
//    Head advances correctly. Pop on empty leaves count=0, no pointer corruption.
//  6 Reset during sAck (rdy=1, ack=1) -> ack=0 and FIFO empty at that edge.
//    With rdy held high, the key is re-accepted once after reset releases.

Source files
------------

// File: rtl/pia_kbd.sv
// pia_kbd: keyboard side of the Apple-1 PIA, rdy/ack key handshake into a type-ahead FIFO read via KBD/KBDCR
module pia_kbd #(
    parameter int          DEPTH      = 4,
    parameter bit          UPCASE     = 1'b1,
    parameter logic [15:0] KBD_ADDR   = 16'hD010,
    parameter logic [15:0] KBDCR_ADDR = 16'hD011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] Address_Bus,
    input  logic        WE,
    output logic [7:0]  Data_Out,
    input  logic        kbd_rdy,
    output logic        kbd_ack,
    input  logic [6:0]  kbd_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE = 2'b01, S_ACK = 2'b10} state_t;

    state_t          state_q, state_d;
    logic            ack_q, ack_d;
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   count_q, count_d;
    logic [6:0]      mem_q [DEPTH];
    logic [6:0]      mem_d [DEPTH];
    logic            empty, full, push, pop;
    logic [6:0]      key, head;

    always_comb begin
        empty   = count_q == '0;
        full    = count_q == CW'(DEPTH);
        // full/empty are pre-edge, so a pop cannot make room for a push on the same edge
        push    = state_q == S_IDLE && kbd_rdy && !full;
        pop     = Address_Bus == KBD_ADDR && !WE && !empty;
        key     = (UPCASE && kbd_data >= 7'h61 && kbd_data <= 7'h7A) ? kbd_data - 7'h20 : kbd_data;
        state_d = state_q == S_ACK ? (kbd_rdy ? S_ACK : S_IDLE) : (push ? S_ACK : S_IDLE);
        ack_d   = state_d == S_ACK;
        wr_d    = push ? wr_q + 1'b1 : wr_q;
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        count_d = count_q + CW'(push) - CW'(pop);
        mem_d   = mem_q;
        if (push) mem_d[wr_q] = key;
        head     = empty ? 7'h00 : mem_q[rd_q];
        Data_Out = Address_Bus == KBD_ADDR ? {~empty, head} :
                   Address_Bus == KBDCR_ADDR ? {~empty, 7'b0} : 8'h00;
    end

    assign kbd_ack = ack_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;
endmodule
